team_06_sample_fifo: RTL and testbench
======================================

TEAM_06_SAMPLE_FIFO -- requirements
Module: team_06_sample_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8: sample width in bits.
REQ-002 SHALL have parameter DEPTH, default 8: FIFO entries; a power of two, at least 2.
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port sample_in, input, WIDTH: parallel sample from the upstream ADC deserializer.
REQ-006 SHALL have port sample_valid, input, 1: upstream "finished" level; may stay high for many clk cycles per sample.
REQ-007 SHALL have port clear, input, 1: synchronous flush.
REQ-008 SHALL have port dout, output, WIDTH: head-of-FIFO sample.
REQ-009 SHALL have port dout_valid, output, 1: high when FIFO is not empty.
REQ-010 SHALL have port dout_ready, input, 1: downstream accepts dout this cycle.
REQ-011 SHALL have port count, output, log2(DEPTH)+1: current occupancy, 0..DEPTH.
REQ-012 SHALL have ports full and empty, output, 1 each: count==DEPTH and count==0 respectively.
REQ-013 SHALL have port overflow, output, 1: sticky flag, set when a sample is dropped.

Function
REQ-014 SHALL register sample_valid into sv_q each cycle; write strobe wr = sample_valid && !sv_q, giving exactly one write per upstream sample.
REQ-015 SHALL write sample_in into mem[wr_ptr] on the clk edge where wr is high and the FIFO is not full, then advance wr_ptr modulo DEPTH.
REQ-016 SHALL define read rd = dout_valid && dout_ready; on rd, rd_ptr SHALL advance modulo DEPTH.
REQ-017 SHALL drive dout combinationally from mem[rd_ptr] (show-ahead); dout is don't-care when empty.
REQ-018 SHALL update count as: +1 on accepted write only, -1 on read only, unchanged on both or neither.
REQ-019 Latency: a sample written into an empty FIFO SHALL appear with dout_valid=1 on the cycle after the write edge.
REQ-020 When full, and wr and rd occur in the same cycle, both SHALL happen; count stays DEPTH and overflow is not set.
REQ-021 When full, and wr occurs without rd, the sample SHALL be dropped, pointers and count SHALL be unchanged, and overflow SHALL be set.
REQ-022 When empty, rd cannot occur; wr SHALL write normally.
REQ-023 Pointer wrap: wr_ptr and rd_ptr SHALL wrap from DEPTH-1 to 0 with no loss of data.
REQ-024 clear SHALL zero wr_ptr, rd_ptr, count and overflow on the next edge, and SHALL take priority over wr and rd in the same cycle; a wr in that cycle is discarded.
REQ-025 clear SHALL NOT affect sv_q, so a level held across clear produces no extra write.
REQ-026 overflow SHALL stay set until clear or rst.

Reset
REQ-027 On rst, wr_ptr, rd_ptr, count, overflow and sv_q SHALL be 0, giving empty=1, full=0 and dout_valid=0.
REQ-028 rst SHALL take priority over clear, wr and rd; mem contents need not be reset.
REQ-029 rst asserted mid-operation SHALL discard all stored samples; the first wr after reset release SHALL land in entry 0.

Configuration
REQ-030 Macro TEAM06_SIGNED_CONV_EN:
- Defined: dout SHALL present mem[rd_ptr] with its MSB inverted, converting offset-binary ADC codes to two's complement; stored data is unchanged.
- Undefined: dout SHALL present mem[rd_ptr] unmodified.
- Ports are identical in both builds.

Verification
REQ-031 Hold sample_valid high for 5 cycles with sample_in=8'hA5, dout_ready=0 -> exactly one write; count=1; dout=8'hA5 (8'h25 with TEAM06_SIGNED_CONV_EN).
REQ-032 Write 9 distinct samples 1..9 with dout_ready=0, DEPTH=8 -> full=1, count=8, overflow=1; draining yields 1..8 in order, and 9 is lost.
REQ-033 Fill to 8, then pulse wr in the same cycle as dout_ready=1 -> count stays 8, overflow=0, new sample becomes the last entry.
REQ-034 Stream 20 samples with dout_ready=1 continuously -> all 20 emerge in order across pointer wraps; count never exceeds 1.
REQ-035 With 3 entries and overflow=1, assert clear together with a wr -> next cycle count=0, empty=1, overflow=0, and no entry written.
REQ-036 Assert rst with 4 entries while sample_valid is held high -> after release, empty=1; one write occurs on release, since sv_q=0, landing in entry 0.

Source files
------------

// File: rtl/team_06_sample_fifo.sv
// Show-ahead sample FIFO fed by a level-style "finished" strobe from an ADC deserializer.
// Optional build macro TEAM06_SIGNED_CONV_EN: present dout as two's complement (MSB inverted).
module team_06_sample_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           sample_in,
    input  logic                       sample_valid,
    input  logic                       clear,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             sv_q;
    logic             wr;
    logic             rd;
    logic             wr_acc;
    logic             wr_drop;

    function automatic logic [WIDTH-1:0] to_output(input logic [WIDTH-1:0] d);
`ifdef TEAM06_SIGNED_CONV_EN
        return {~d[WIDTH-1], d[WIDTH-2:0]};
`else
        return d;
`endif
    endfunction

    // Stage 0: edge-detect the upstream level and qualify reads/writes
    assign wr         = sample_valid && !sv_q;
    assign empty      = (count == '0);
    assign full       = (count == CNT_W'(DEPTH));
    assign dout_valid = !empty;
    assign rd         = dout_valid && dout_ready;
    // A full FIFO still accepts a write when the head is leaving on the same edge
    assign wr_acc     = wr && !rst && !clear && (!full || rd);
    assign wr_drop    = wr && !clear && full && !rd;
    assign dout       = to_output(mem[rd_ptr]);

    // Stage 1: storage (data path, never reset)
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= sample_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sv_q     <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            // sv_q keeps tracking through clear so a held level cannot re-trigger
            sv_q <= sample_valid;
            if (clear) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else begin
                if (wr_acc) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (rd) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                if (wr_acc && !rd) begin
                    count <= count + CNT_W'(1);
                end else if (rd && !wr_acc) begin
                    count <= count - CNT_W'(1);
                end
                if (wr_drop) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_team_06_sample_fifo.sv
// Scoreboard bench for team_06_sample_fifo: a queue holds the expected FIFO contents.
module tb_team_06_sample_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] sample_in = '0;
    logic             sample_valid = 1'b0;
    logic             clear = 1'b0;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready = 1'b0;
    logic [3:0]       count;
    logic             full;
    logic             empty;
    logic             overflow;

    logic [7:0] sb_q [$];
    logic       m_svq = 1'b0;
    logic       m_ovf = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;

    team_06_sample_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .clear(clear), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .count(count), .full(full), .empty(empty), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] conv(input logic [7:0] d);
`ifdef TEAM06_SIGNED_CONV_EN
        return d ^ 8'h80;
`else
        return d;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // One clock of stimulus; the model advances on the same edge and is checked after it
    task automatic step(input logic sv, input logic [7:0] din, input logic rdy,
                        input logic clr, input logic rs);
        logic wr;
        logic rd;
        @(negedge clk);
        sample_valid = sv;
        sample_in    = din;
        dout_ready   = rdy;
        clear        = clr;
        rst          = rs;
        #1;
        wr = sv && !m_svq;
        rd = (sb_q.size() != 0) && rdy;
        if (rs) begin
            sb_q.delete();
            m_ovf = 1'b0;
            m_svq = 1'b0;
        end else begin
            m_svq = sv;
            if (clr) begin
                sb_q.delete();
                m_ovf = 1'b0;
            end else begin
                if (rd) begin
                    check("dout_pop", 32'(dout), 32'(conv(sb_q[0])));
                    void'(sb_q.pop_front());
                end
                if (wr) begin
                    if (sb_q.size() < DEPTH) sb_q.push_back(din);
                    else m_ovf = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        check("count", 32'(count), 32'(sb_q.size()));
        check("full", 32'(full), 32'(sb_q.size() == DEPTH));
        check("empty", 32'(empty), 32'(sb_q.size() == 0));
        check("dout_valid", 32'(dout_valid), 32'(sb_q.size() != 0));
        check("overflow", 32'(overflow), 32'(m_ovf));
        if (sb_q.size() != 0) check("dout_head", 32'(dout), 32'(conv(sb_q[0])));
    endtask

    task automatic put(input logic [7:0] d, input logic rdy);
        step(1'b1, d, rdy, 1'b0, 1'b0);
        step(1'b0, d, rdy, 1'b0, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        // reset state
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // held level gives one write
        for (int i = 0; i < 5; i++) step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("hold_count", 32'(count), 32'd1);
`ifdef TEAM06_SIGNED_CONV_EN
        check("hold_dout", 32'(dout), 32'h25);
`else
        check("hold_dout", 32'(dout), 32'hA5);
`endif
        drain(2);

        // overfill: 9 lost
        for (int i = 1; i <= 9; i++) put(8'(i), 1'b0);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_flag", 32'(overflow), 32'd1);
        drain(8);
        check("ovf_sticky", 32'(overflow), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // full with simultaneous read and write
        for (int i = 0; i < 8; i++) put(8'(8'h10 + i), 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        check("rw_full_count", 32'(count), 32'd8);
        check("rw_full_ovf", 32'(overflow), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        drain(8);

        // streaming across pointer wraps
        for (int i = 0; i < 20; i++) begin
            put(8'(8'h40 + i), 1'b1);
            check("stream_le1", 32'(count <= 4'd1), 32'd1);
        end
        drain(1);

        // clear with concurrent write, level held across clear
        for (int i = 0; i < 9; i++) put(8'(8'hC0 + i), 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("pre_clr_count", 32'(count), 32'd3);
        step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
        check("clr_empty", 32'(empty), 32'd1);
        check("clr_ovf", 32'(overflow), 32'd0);
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        check("clr_noextra", 32'(count), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // reset mid-operation with level held
        for (int i = 0; i < 4; i++) put(8'(8'h20 + i), 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
        check("rst_empty", 32'(empty), 32'd1);
        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        check("rst_release_count", 32'(count), 32'd1);
        check("rst_release_dout", 32'(dout), 32'(conv(8'h55)));
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        drain(2);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 60) == 0), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
